// File: rtl/stack_id_sorter.sv
// Per-die 3D-stack ID assignment engine: learns its ID from the die below, announces
// itself upward at rising power levels and waits for the die above to acknowledge.
module stack_id_sorter #(
    parameter logic [15:0] SYNC_WORD   = 16'hBEEF,
    parameter logic [3:0]  HDR         = 4'hA,
    parameter int          ACK_TIMEOUT = 20,
    parameter int          LEVEL_MAX   = 15
) (
    input  logic        div_8_clk,
    input  logic        rst_n,
    input  logic        f_layer,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    output logic [3:0]  chip_id,
    output logic [3:0]  pwr_upper,
    output logic [3:0]  pwr_level,
    output logic        sort_finish,
    output logic        is_top,
    output logic        proto_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RX_ID,
        REPLY,
        TX,
        WAIT_ACK,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic          good_frame;
    logic          ack;
    logic          timeout;
    logic          at_max;
    logic [3:0]    id_next;
    logic          set_top;
    logic          set_err;

    assign good_frame = rx_valid && (rx_data[15:0] == SYNC_WORD) && (rx_data[31:28] == HDR);
    assign id_next    = chip_id + 4'd1;
    assign ack        = good_frame && (rx_data[23:20] == id_next);
    assign timeout    = (timer == TW'(ACK_TIMEOUT - 1));
    assign at_max     = (pwr_level == 4'(LEVEL_MAX));
    assign sort_finish = (state == DONE);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        tx_valid = 1'b0;
        tx_data  = 32'h0;
        set_top  = 1'b0;
        set_err  = 1'b0;
        case (state)
            IDLE: state_nx = f_layer ? TX : RX_ID;
            RX_ID: begin
                if (good_frame) begin
                    // ID 0xF leaves no room for a die above, so this die is the top.
                    if (rx_data[19:16] == 4'hF) begin
                        state_nx = DONE;
                        set_top  = 1'b1;
                    end else begin
                        state_nx = REPLY;
                    end
                end
            end
            REPLY: begin
                tx_valid = 1'b1;
                tx_data  = {HDR, pwr_upper, chip_id, id_next, SYNC_WORD};
                state_nx = TX;
            end
            TX: begin
                tx_valid = 1'b1;
                tx_data  = {HDR, pwr_level, chip_id, id_next, SYNC_WORD};
                state_nx = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack) begin
                    state_nx = DONE;
                end else begin
                    set_err = good_frame;
                    if (timeout) begin
                        state_nx = at_max ? DONE : TX;
                        set_top  = at_max;
                    end
                end
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            chip_id   <= 4'h0;
            pwr_upper <= 4'h0;
            pwr_level <= 4'h0;
            is_top    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= (state == WAIT_ACK) ? timer + TW'(1) : '0;
            if (state == IDLE) begin
                chip_id <= f_layer ? 4'h1 : 4'h0;
            end
            if (state == RX_ID && good_frame) begin
                chip_id   <= rx_data[19:16];
                pwr_upper <= rx_data[27:24];
            end
            if (state_nx == TX && state != TX && !at_max) begin
                pwr_level <= pwr_level + 4'd1;
            end
            if (set_top) begin
                is_top <= 1'b1;
            end
            if (set_err) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_id_sorter.sv
// Scoreboard bench for stack_id_sorter: expected frames queued with stimulus and
// compared as the DUT transmits; state outputs checked at scenario milestones.
module tb_stack_id_sorter;

    logic        div_8_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        f_layer   = 1'b0;
    logic        rx_valid  = 1'b0;
    logic [31:0] rx_data   = 32'h0;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [3:0]  chip_id;
    logic [3:0]  pwr_upper;
    logic [3:0]  pwr_level;
    logic        sort_finish;
    logic        is_top;
    logic        proto_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [31:0] sb[$];
    int          tx_cycles[$];

    stack_id_sorter dut (
        .div_8_clk  (div_8_clk),
        .rst_n      (rst_n),
        .f_layer    (f_layer),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .chip_id    (chip_id),
        .pwr_upper  (pwr_upper),
        .pwr_level  (pwr_level),
        .sort_finish(sort_finish),
        .is_top     (is_top),
        .proto_err  (proto_err)
    );

    always #5 div_8_clk = ~div_8_clk;

    always @(posedge div_8_clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame monitor: every transmitted word must match the head of the scoreboard.
    always @(negedge div_8_clk) begin
        logic [31:0] exp_w;
        if (rst_n) begin
            if (tx_valid) begin
                tx_cycles.push_back(cyc);
                exp_w = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
                check("tx_frame", {32'h0, tx_data}, {32'h0, exp_w});
            end else begin
                check("tx_idle_zero", {32'h0, tx_data}, 64'h0);
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return {16'h0, tx_valid, tx_data, chip_id, pwr_upper, pwr_level,
                sort_finish, is_top, proto_err};
    endfunction

    task automatic start(input logic bottom);
        rst_n    = 1'b0;
        f_layer  = bottom;
        rx_valid = 1'b0;
        rx_data  = 32'h0;
        repeat (2) @(negedge div_8_clk);
        check("sb_drained", sb.size(), 0);
        sb.delete();
        tx_cycles.delete();
        check("reset_outputs", all_outs(), 64'h0);
    endtask

    task automatic send(input logic [31:0] frame);
        rx_data  = frame;
        rx_valid = 1'b1;
        @(negedge div_8_clk);
        rx_valid = 1'b0;
        rx_data  = 32'h0;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles && !sort_finish; i++) @(negedge div_8_clk);
        check("done_reached", sort_finish, 1);
    endtask

    initial begin
        logic found;

        // Bottom die, nobody above: 15 announce attempts, then top of stack.
        start(1'b1);
        for (int l = 1; l <= 15; l++) sb.push_back({4'hA, 4'(l), 4'h1, 4'h2, 16'hBEEF});
        rst_n = 1'b1;
        wait_done(400);
        check("s1_is_top", is_top, 1);
        check("s1_chip_id", chip_id, 1);
        check("s1_level", pwr_level, 15);
        check("s1_proto_err", proto_err, 0);
        check("s1_tx_count", tx_cycles.size(), 15);
        if (tx_cycles.size() >= 2) check("s1_tx_period", tx_cycles[1] - tx_cycles[0], 21);

        // Middle die: invalid-qualified frame ignored, then ID 2 assigned and ACKed.
        start(1'b0);
        rx_data = 32'hA512BEEF;
        rst_n   = 1'b1;
        repeat (4) @(negedge div_8_clk);
        check("s2_ignore_id", chip_id, 0);
        check("s2_ignore_state", sort_finish, 0);
        f_layer = 1'b1;
        sb.push_back(32'hA523BEEF);
        sb.push_back(32'hA123BEEF);
        send(32'hA512BEEF);
        check("s2_chip_id", chip_id, 2);
        check("s2_pwr_upper", pwr_upper, 5);
        repeat (4) @(negedge div_8_clk);
        check("s3_wait", sort_finish, 0);
        send(32'hA034BEEF);
        check("s3_done", sort_finish, 1);
        check("s3_is_top", is_top, 0);
        check("s3_proto_err", proto_err, 0);
        check("s3_level", pwr_level, 1);

        // Unexpected frame in WAIT_ACK flags an error; a bad sync word is ignored.
        start(1'b0);
        rst_n = 1'b1;
        sb.push_back(32'hA378BEEF);
        sb.push_back(32'hA178BEEF);
        @(negedge div_8_clk);
        send(32'hA327BEEF);
        repeat (3) @(negedge div_8_clk);
        send(32'hA077BEEF);
        check("s4_proto_err", proto_err, 1);
        check("s4_still_wait", sort_finish, 0);
        send(32'hA080BEEE);
        check("s4_bad_sync", sort_finish, 0);
        send(32'hA080BEEF);
        check("s4_done", sort_finish, 1);
        check("s4_err_sticky", proto_err, 1);
        check("s4_is_top", is_top, 0);
        check("s4_chip_id", chip_id, 7);

        // ACK on the very last timeout cycle at LEVEL_MAX beats the timeout.
        start(1'b1);
        for (int l = 1; l <= 15; l++) sb.push_back({4'hA, 4'(l), 4'h1, 4'h2, 16'hBEEF});
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge div_8_clk);
            if (tx_valid && tx_data[27:24] == 4'hF) begin
                found = 1'b1;
                break;
            end
        end
        check("s5_level15_seen", found, 1);
        repeat (20) @(negedge div_8_clk);
        check("s5_before_ack", sort_finish, 0);
        send(32'hA020BEEF);
        check("s5_done", sort_finish, 1);
        check("s5_is_top", is_top, 0);
        check("s5_level", pwr_level, 15);

        // ID overflow from below: top of stack with no transmission.
        start(1'b0);
        rst_n = 1'b1;
        @(negedge div_8_clk);
        send(32'hAB1FBEEF);
        check("s6_done", sort_finish, 1);
        check("s6_is_top", is_top, 1);
        check("s6_chip_id", chip_id, 4'hF);
        check("s6_pwr_upper", pwr_upper, 4'hB);
        repeat (3) @(negedge div_8_clk);
        check("s6_no_tx", tx_cycles.size(), 0);

        // Asynchronous reset in WAIT_ACK clears outputs without a clock edge.
        start(1'b1);
        sb.push_back(32'hA112BEEF);
        rst_n = 1'b1;
        repeat (6) @(negedge div_8_clk);
        check("s7_waiting", sort_finish, 0);
        check("s7_level", pwr_level, 1);
        #2 rst_n = 1'b0;
        #1 check("s7_async_reset", all_outs(), 64'h0);
        repeat (2) @(negedge div_8_clk);
        check("s7_sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
